// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter
//   Central arbiter for a shared serial bus with NUM_INIT initiator ports.
//   Issues a registered one-hot grant held for the whole transaction and
//   supports one parked split transaction that is re-granted first once the
//   target signals split completion.
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
//   otherwise fixed priority (lowest index wins) and no pointer logic.
module serial_bus_arbiter #(
    parameter int NUM_INIT = 2,
    parameter int IDX_W    = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_INIT-1:0] req,
    input  logic                target_split,
    input  logic                split_done,
    output logic [NUM_INIT-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                bus_busy,
    output logic                split_pending,
    output logic [IDX_W-1:0]    split_owner,
    output logic                split_err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0]          state;
    logic                done_seen;   // split_done arrived while the bus was owned
    logic [NUM_INIT-1:0] eligible;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]    rr_ptr;      // index of the most recent grant
`endif

    function automatic logic [NUM_INIT-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_INIT-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Requests that may compete: the parked initiator sits out until split_done.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        eligible = req;
        if (split_pending) begin
            eligible[split_owner] = 1'b0;
        end
    end

    // Pick the arbitration winner among eligible requests.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NUM_INIT; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_INIT);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int i = NUM_INIT - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    // Arbiter FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            grant_idx     <= '0;
            bus_busy      <= 1'b0;
            split_pending <= 1'b0;
            split_owner   <= '0;
            split_err     <= 1'b0;
            done_seen     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr        <= IDX_W'(NUM_INIT - 1);
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            split_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (split_pending && (split_done || done_seen)) begin
                        // Parked split resumes ahead of any new request.
                        state         <= OWNED;
                        grant         <= to_onehot(split_owner);
                        grant_idx     <= split_owner;
                        bus_busy      <= 1'b1;
                        split_pending <= 1'b0;
                        done_seen     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr        <= split_owner;
`endif
                    end else if (win_found) begin
                        state     <= OWNED;
                        grant     <= to_onehot(win_idx);
                        grant_idx <= win_idx;
                        bus_busy  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr    <= win_idx;
`endif
                    end
                end

                OWNED: begin
                    // Completion may race ahead of the bus becoming free.
                    if (split_pending && split_done) begin
                        done_seen <= 1'b1;
                    end
                    if (target_split && !split_pending) begin
                        // Park the owner and free the bus; wins over a req drop.
                        split_owner   <= grant_idx;
                        split_pending <= 1'b1;
                        state         <= IDLE;
                        grant         <= '0;
                        bus_busy      <= 1'b0;
                    end else begin
                        // Only one split may be outstanding; the transfer goes on unsplit.
                        if (target_split) begin
                            split_err <= 1'b1;
                        end
                        if (!req[grant_idx]) begin
                            state    <= IDLE;
                            grant    <= '0;
                            bus_busy <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
